// File: rtl/cepstral_delta_pkg.sv
// Shared definitions for the cepstral delta engine.
//   - output kind encodings carried on out_kind
//   - FSM state enum (CEP -> DELTA -> DDELTA)
//   - frames_seen thresholds that gate the warm-up zeros
//   - slot_inc: 3-slot ring pointer increment
//   - sat_sub: signed subtract, saturating or wrapping, at a runtime width
package cepstral_delta_pkg;

    localparam logic [1:0] KIND_CEP    = 2'd0;
    localparam logic [1:0] KIND_DELTA  = 2'd1;
    localparam logic [1:0] KIND_DDELTA = 2'd2;

    // frames_seen saturates at FS_MAX; deltas need c[t-2], delta-deltas need d[t-2]
    localparam logic [2:0] FS_MAX    = 3'd5;
    localparam logic [2:0] FS_DELTA  = 3'd3;
    localparam logic [2:0] FS_DDELTA = 3'd5;

    // Widest coefficient sat_sub can handle
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        CEP    = 2'd0,
        DELTA  = 2'd1,
        DDELTA = 2'd2
    } state_e;

    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // a and b are w-bit values already sign-extended to MAX_W. The caller keeps the
    // low w bits of the result, so the non-saturating path wraps modulo 2^w.
    function automatic logic [MAX_W-1:0] sat_sub(input logic signed [MAX_W-1:0] a,
                                                 input logic signed [MAX_W-1:0] b,
                                                 input logic                    sat,
                                                 input int unsigned             w);
        logic signed [MAX_W:0] diff;
        logic signed [MAX_W:0] one;
        logic signed [MAX_W:0] max_v;
        logic signed [MAX_W:0] min_v;
        one     = '0;
        one[0]  = 1'b1;
        diff    = $signed({a[MAX_W-1], a}) - $signed({b[MAX_W-1], b});
        max_v   = (one <<< (w - 1)) - one;
        min_v   = -(one <<< (w - 1));
        if (sat && (diff > max_v)) begin
            return max_v[MAX_W-1:0];
        end
        if (sat && (diff < min_v)) begin
            return min_v[MAX_W-1:0];
        end
        return diff[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/cepstral_delta_engine_if.sv
// Stream interface of the cepstral delta engine.
//   flush                         sync drop of history and partial frame
//   in_data/in_valid/in_ready     coefficient input, index order 0..N_COEF-1
//   out_data/out_kind/out_last    output word, its kind and end-of-frame flag
//   out_valid/out_ready           output handshake
//   frames_seen                   saturating frame count (debug)
// master: the surrounding environment; slave: the engine.
interface cepstral_delta_engine_if #(
    parameter int unsigned DATA_W = 32
);
    import cepstral_delta_pkg::*;

    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_kind;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        frames_seen;

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_kind, out_last, out_valid, frames_seen
    );

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, out_data, out_kind, out_last, out_valid, frames_seen
    );

endinterface

// File: rtl/frame_ring3.sv
// Three-frame history store: 3 slots x N_COEF words.
//   clk_i          clock
//   we_i           write enable
//   wr_slot_i      slot written (0..2)
//   wr_idx_i       coefficient index written
//   wr_data_i      write data
//   rd_slot_t_i    slot of frame t
//   rd_slot_t2_i   slot of frame t-2
//   rd_idx_i       coefficient index read from both slots
//   rd_t_o         combinational read of [rd_slot_t_i][rd_idx_i]
//   rd_t2_o        combinational read of [rd_slot_t2_i][rd_idx_i]
// Contents are deliberately not reset; the owner masks stale data.
module frame_ring3 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_COEF = 13,
    localparam int unsigned IdxW  = $clog2(N_COEF)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [1:0]        wr_slot_i,
    input  logic [IdxW-1:0]   wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [1:0]        rd_slot_t_i,
    input  logic [1:0]        rd_slot_t2_i,
    input  logic [IdxW-1:0]   rd_idx_i,
    output logic [DATA_W-1:0] rd_t_o,
    output logic [DATA_W-1:0] rd_t2_o
);

    logic [DATA_W-1:0] mem_q [3][N_COEF];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_slot_i][wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_t_o  = mem_q[rd_slot_t_i][rd_idx_i];
    assign rd_t2_o = mem_q[rd_slot_t2_i][rd_idx_i];

endmodule

// File: rtl/cepstral_delta_engine.sv
// Cepstral delta engine: passes each frame of N_COEF coefficients through, then appends
// per-coefficient deltas d[t]=c[t]-c[t-2] and delta-deltas dd[t]=d[t]-d[t-2] (per MODE).
//   clk       clock
//   rst_n     asynchronous active-low reset
//   eng_io    stream interface (slave): flush, input/output handshakes, frames_seen
// Output frames are always N_COEF*(MODE+1) words; warm-up words are zero, not dropped.
module cepstral_delta_engine
    import cepstral_delta_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_COEF   = 13,
    parameter int unsigned MODE     = 2,
    parameter int unsigned SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cepstral_delta_engine_if.slave  eng_io
);

    localparam int unsigned     IdxW    = $clog2(N_COEF);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_COEF - 1);
    localparam logic            SatEn   = (SATURATE != 0);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [1:0]        wr_frame_q, wr_frame_d;
    logic [2:0]        frames_seen_q, frames_seen_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [1:0]        out_kind_q, out_kind_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              slot_free;
    logic              accept;
    logic              cep_we;
    logic              dlt_we;
    logic [1:0]        t2_slot;
    logic [DATA_W-1:0] cep_t, cep_t2;
    logic [DATA_W-1:0] dlt_t, dlt_t2;
    logic [DATA_W-1:0] delta_val, ddelta_val;

    // The output register can take a new word when empty or when its word leaves now
    assign slot_free       = !out_valid_q || eng_io.out_ready;
    assign eng_io.in_ready = (state_q == CEP) && slot_free && !eng_io.flush;
    assign accept          = eng_io.in_ready && eng_io.in_valid;

    // wr_frame holds frame t until its whole output frame is emitted, so t-2 is the next slot
    assign t2_slot = slot_inc(wr_frame_q);

    assign delta_val  = (frames_seen_q >= FS_DELTA)
                      ? DATA_W'(sat_sub(MAX_W'($signed(cep_t)), MAX_W'($signed(cep_t2)),
                                        SatEn, DATA_W))
                      : '0;
    assign ddelta_val = (frames_seen_q >= FS_DDELTA)
                      ? DATA_W'(sat_sub(MAX_W'($signed(dlt_t)), MAX_W'($signed(dlt_t2)),
                                        SatEn, DATA_W))
                      : '0;

    frame_ring3 #(
        .DATA_W (DATA_W),
        .N_COEF (N_COEF)
    ) u_cep_ring (
        .clk_i        (clk),
        .we_i         (cep_we),
        .wr_slot_i    (wr_frame_q),
        .wr_idx_i     (idx_q),
        .wr_data_i    (eng_io.in_data),
        .rd_slot_t_i  (wr_frame_q),
        .rd_slot_t2_i (t2_slot),
        .rd_idx_i     (idx_q),
        .rd_t_o       (cep_t),
        .rd_t2_o      (cep_t2)
    );

    frame_ring3 #(
        .DATA_W (DATA_W),
        .N_COEF (N_COEF)
    ) u_dlt_ring (
        .clk_i        (clk),
        .we_i         (dlt_we),
        .wr_slot_i    (wr_frame_q),
        .wr_idx_i     (idx_q),
        .wr_data_i    (delta_val),
        .rd_slot_t_i  (wr_frame_q),
        .rd_slot_t2_i (t2_slot),
        .rd_idx_i     (idx_q),
        .rd_t_o       (dlt_t),
        .rd_t2_o      (dlt_t2)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wr_frame_d    = wr_frame_q;
        frames_seen_d = frames_seen_q;
        out_valid_d   = out_valid_q && !eng_io.out_ready;
        out_last_d    = out_last_q;
        out_kind_d    = out_kind_q;
        out_data_d    = out_data_q;
        cep_we        = 1'b0;
        dlt_we        = 1'b0;

        unique case (state_q)
            CEP: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = eng_io.in_data;
                    out_kind_d  = KIND_CEP;
                    out_last_d  = 1'b0;
                    cep_we      = 1'b1;
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (frames_seen_q != FS_MAX) begin
                            frames_seen_d = frames_seen_q + 3'd1;
                        end
                        if (MODE == 0) begin
                            out_last_d = 1'b1;
                            wr_frame_d = slot_inc(wr_frame_q);
                        end else begin
                            state_d = DELTA;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            DELTA: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = delta_val;
                    out_kind_d  = KIND_DELTA;
                    out_last_d  = 1'b0;
                    dlt_we      = 1'b1;
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (MODE == 1) begin
                            out_last_d = 1'b1;
                            state_d    = CEP;
                            wr_frame_d = slot_inc(wr_frame_q);
                        end else begin
                            state_d = DDELTA;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            DDELTA: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = ddelta_val;
                    out_kind_d  = KIND_DDELTA;
                    out_last_d  = 1'b0;
                    if (idx_q == LastIdx) begin
                        idx_d      = '0;
                        out_last_d = 1'b1;
                        state_d    = CEP;
                        wr_frame_d = slot_inc(wr_frame_q);
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: begin
                state_d = CEP;
            end
        endcase

        // Flush wins over everything, including a word that is still waiting downstream
        if (eng_io.flush) begin
            state_d       = CEP;
            idx_d         = '0;
            frames_seen_d = '0;
            out_valid_d   = 1'b0;
            dlt_we        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CEP;
            idx_q         <= '0;
            wr_frame_q    <= '0;
            frames_seen_q <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_kind_q    <= KIND_CEP;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_frame_q    <= wr_frame_d;
            frames_seen_q <= frames_seen_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_kind_q    <= out_kind_d;
            out_data_q    <= out_data_d;
        end
    end

    assign eng_io.out_valid   = out_valid_q;
    assign eng_io.out_last    = out_last_q;
    assign eng_io.out_kind    = out_kind_q;
    assign eng_io.out_data    = out_data_q;
    assign eng_io.frames_seen = frames_seen_q;

endmodule
